// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: a four-state fetch FSM (REQ/WAIT/HOLD/DROP) that
// keeps one instruction-memory request in flight and feeds the IF/ID register.
// It has a one-entry skid buffer for responses that arrive while decode stalls.
// Define FETCH_PERF_COUNTER_EN to add the fetch_count output.
module instruction_fetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [31:0]           id_instruction,
  output logic [6:0]            id_opcode
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} fetchState_t;

  fetchState_t           r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_reqValid;
  logic                  r_idValid;
  logic [ADDR_WIDTH-1:0] r_idPc;
  logic [31:0]           r_idInstr;
  logic [ADDR_WIDTH-1:0] r_bufPc;
  logic [31:0]           r_bufInstr;

  logic                  w_handshake;
  logic                  w_slotFree;
  logic                  w_loadRsp;
  logic                  w_loadBuf;
  logic [ADDR_WIDTH-1:0] w_redirectTarget;
  logic [ADDR_WIDTH-1:0] w_pcNext;

  // The request flag is held low for as long as reset is asserted, even though
  // the state register only updates on the edge.
  assign imem_req_valid   = r_reqValid && rst_n;
  assign imem_req_addr    = r_pc;
  assign w_handshake      = imem_req_valid && imem_req_ready;
  assign w_slotFree       = !r_idValid || !stall;
  // A redirect cancels any load that would otherwise happen this cycle.
  assign w_loadRsp        = (r_state == S_WAIT) && imem_rsp_valid && w_slotFree && !redirect_valid;
  assign w_loadBuf        = (r_state == S_HOLD) && !stall && !redirect_valid;
  assign w_redirectTarget = redirect_pc & ~ADDR_WIDTH'(3);
  assign w_pcNext         = r_pc + ADDR_WIDTH'(4);

  assign id_valid       = r_idValid;
  assign id_pc          = r_idPc;
  assign id_instruction = r_idInstr;
  assign id_opcode      = r_idInstr[6:0];

  // Fetch FSM, PC, skid buffer and IF/ID register; redirect outranks everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_reqValid <= 1'b1;
      r_pc       <= RESET_PC;
      r_idValid  <= 1'b0;
      r_idPc     <= '0;
      r_idInstr  <= '0;
      r_bufPc    <= '0;
      r_bufInstr <= '0;
    end else begin
      if (!stall || redirect_valid) begin
        r_idValid <= 1'b0;
      end
      if (redirect_valid) begin
        r_pc <= w_redirectTarget;
        case (r_state)
          S_REQ: begin
            if (w_handshake) begin
              r_state    <= S_DROP;
              r_reqValid <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_state    <= S_REQ;
              r_reqValid <= 1'b1;
            end else begin
              r_state    <= S_DROP;
              r_reqValid <= 1'b0;
            end
          end
          S_HOLD: begin
            r_state    <= S_REQ;
            r_reqValid <= 1'b1;
          end
          S_DROP: begin
            if (imem_rsp_valid) begin
              r_state    <= S_REQ;
              r_reqValid <= 1'b1;
            end
          end
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_handshake) begin
              r_state    <= S_WAIT;
              r_reqValid <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_pc <= w_pcNext;
              if (w_loadRsp) begin
                r_idValid  <= 1'b1;
                r_idPc     <= r_pc;
                r_idInstr  <= imem_rsp_data;
                r_state    <= S_REQ;
                r_reqValid <= 1'b1;
              end else begin
                r_bufPc    <= r_pc;
                r_bufInstr <= imem_rsp_data;
                r_state    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_loadBuf) begin
              r_idValid  <= 1'b1;
              r_idPc     <= r_bufPc;
              r_idInstr  <= r_bufInstr;
              r_state    <= S_REQ;
              r_reqValid <= 1'b1;
            end
          end
          S_DROP: begin
            if (imem_rsp_valid) begin
              r_state    <= S_REQ;
              r_reqValid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] r_fetchCount;

  assign fetch_count = r_fetchCount;

  // Count every instruction that actually lands in the IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetchCount <= '0;
    end else if (w_loadRsp || w_loadBuf) begin
      r_fetchCount <= r_fetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage. A behavioural memory serves
// requests with random latency. A reference model predicts request addresses and
// the ordered stream of instructions that must reach decode. A monitor checks the
// IF/ID register against that stream after every clock edge.
module tb_instruction_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [6:0]  id_opcode;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  fetch_t      expQ[$];
  logic [31:0] expAddr   = TB_RESET_PC;
  int          delivered = 0;

  // Memory model state
  bit          memPending = 0;
  logic [31:0] memAddr    = '0;
  int          memDelay   = 0;
  int          maxDelay   = 0;
  bit          lastRstN   = 0;

  instruction_fetch_stage #(
    .ADDR_WIDTH(32),
    .RESET_PC  (TB_RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instruction(id_instruction),
    .id_opcode     (id_opcode)
`ifdef FETCH_PERF_COUNTER_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents; address 0 holds "addi x1, x0, 5".
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then just before the edge update the memory and
  // the reference model with what that edge will do.
  task automatic applyStimulus(input bit rstN, input bit rdy, input bit stl,
                               input bit redir, input logic [31:0] rpc);
    bit hs;
    bit pendingBefore;
    @(negedge clk);
    rst_n          = rstN;
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (memPending && memDelay == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memAddr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #4;
    if (!rstN) begin
      checkOutput("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
      memPending = 0;
      expQ.delete();
      expAddr = TB_RESET_PC;
    end else begin
      if (!lastRstN) begin
        checkOutput("req_valid_after_reset", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("req_addr_after_reset", imem_req_addr, TB_RESET_PC);
      end
      pendingBefore = memPending;
      if (imem_rsp_valid) memPending = 0;
      else if (memPending && memDelay > 0) memDelay--;
      hs = imem_req_valid && rdy;
      if (hs) begin
        checkOutput("req_addr", imem_req_addr, expAddr);
        checkOutput("one_outstanding", {31'b0, pendingBefore}, 32'd0);
        memPending = 1;
        memAddr    = imem_req_addr;
        memDelay   = $urandom_range(0, maxDelay);
        expQ.push_back('{pc: expAddr, instr: memWord(expAddr)});
        expAddr = expAddr + 32'd4;
      end
      if (redir) begin
        expQ.delete();
        expAddr = rpc & ~32'd3;
      end
    end
    lastRstN = rstN;
  endtask

  // Monitor: after each edge decide whether a new instruction was presented to
  // decode and compare it with the head of the expected stream.
  initial begin
    bit          lastIdValid = 0;
    logic [31:0] lastPc      = '0;
    logic [31:0] lastInstr   = '0;
    bit          newLoad;
    fetch_t      e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        checkOutput("reset_id_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("reset_id_pc", id_pc, 32'd0);
        checkOutput("reset_id_instruction", id_instruction, 32'd0);
        delivered = 0;
`ifdef FETCH_PERF_COUNTER_EN
        checkOutput("reset_fetch_count", fetch_count, 32'd0);
`endif
      end else begin
        newLoad = id_valid && !(lastIdValid && stall);
        if (newLoad) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_load: got pc 0x%08h instr 0x%08h, expected no instruction",
                     id_pc, id_instruction);
          end else begin
            e = expQ.pop_front();
            checkOutput("id_pc", id_pc, e.pc);
            checkOutput("id_instruction", id_instruction, e.instr);
            checkOutput("id_opcode", {25'b0, id_opcode}, {25'b0, e.instr[6:0]});
          end
          delivered++;
        end else if (id_valid) begin
          checkOutput("hold_id_pc", id_pc, lastPc);
          checkOutput("hold_id_instruction", id_instruction, lastInstr);
        end
`ifdef FETCH_PERF_COUNTER_EN
        checkOutput("fetch_count", fetch_count, delivered);
`endif
      end
      lastIdValid = (rst_n == 1'b1) ? id_valid : 1'b0;
      lastPc      = id_pc;
      lastInstr   = id_instruction;
    end
  end

  initial begin
    int startDelivered;
    int waited;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset, then a zero-wait memory with no stalls: one instruction per two cycles.
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    maxDelay       = 0;
    startDelivered = delivered;
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 32'h0);
    testsRun++;
    if (delivered - startDelivered < 9) begin
      testsFailed++;
      $display("[TB] FAIL throughput: got %0d instructions in 20 cycles, expected at least 9",
               delivered - startDelivered);
    end

    // Decode stalls long enough for a response to land in the skid buffer.
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 32'h0);

    // Redirect to the top of the address space; the PC must wrap to zero.
    applyStimulus(1, 1, 0, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 32'h0);

    // Redirect just after a handshake so the in-flight response is dropped.
    maxDelay = 2;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 32'h0000_0103);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 32'h0);

    // Random traffic: latency, back-pressure, stalls, redirects and resets.
    maxDelay = 3;
    for (int i = 0; i < 3000; i++) begin
      bit          rstN;
      bit          redir;
      logic [31:0] rpc;
      rstN  = ($urandom_range(0, 149) != 0);
      redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else rpc = $urandom;
      applyStimulus(rstN, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, redir, rpc);
    end

    // Drain: stop accepting requests and let every expected instruction arrive.
    waited = 0;
    while ((expQ.size() != 0 || memPending) && waited < 40) begin
      applyStimulus(1, 0, 0, 0, 32'h0);
      waited++;
    end
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("drain_remaining", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
